line_buffer_5row: RTL

//  Upstream feeder for the 5x5 window/Gaussian stage. Takes a raster pixel stream (one pixel per

---
 rtl/line_buffer_5row_if.sv | 42 ++++
 rtl/line_buffer_5row.sv | 101 ++++++++++
 2 files changed

// File: rtl/line_buffer_5row_if.sv
// Pixel stream bundle for the 5-row line buffer.
// master drives pixels in, slave returns the aligned column.
interface line_buffer_5row_if #(
  parameter int WIDTH = 24
);
  logic             valid_in;
  logic [WIDTH-1:0] din;
  logic             valid_out;
  logic [WIDTH-1:0] dout1;
  logic [WIDTH-1:0] dout2;
  logic [WIDTH-1:0] dout3;
  logic [WIDTH-1:0] dout4;
  logic [WIDTH-1:0] dout5;
  logic             eol_out;
  logic             eof_out;

  modport master (
    output valid_in,
    output din,
    input  valid_out,
    input  dout1,
    input  dout2,
    input  dout3,
    input  dout4,
    input  dout5,
    input  eol_out,
    input  eof_out
  );

  modport slave (
    input  valid_in,
    input  din,
    output valid_out,
    output dout1,
    output dout2,
    output dout3,
    output dout4,
    output dout5,
    output eol_out,
    output eof_out
  );
endinterface

// File: rtl/line_buffer_5row.sv
// Four-line buffer that presents a 5-pixel vertical column
// per input pixel to the 5x5 window stage.
module line_buffer_5row #(
  parameter int WIDTH      = 24,
  parameter int PIC_WIDTH  = 480,
  parameter int PIC_HEIGHT = 272
) (
  input  logic clk,
  input  logic rst_n,
  line_buffer_5row_if.slave bus
);

  localparam int AW =
    (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
  localparam logic [8:0] COL_LAST = 9'(PIC_WIDTH - 1);
  localparam logic [8:0] ROW_LAST = 9'(PIC_HEIGHT - 1);
  localparam logic [8:0] PRIME_ROWS = 9'd4;

  logic [8:0]       col_cnt;
  logic [8:0]       row_cnt;
  logic [AW-1:0]    addr;

  logic [WIDTH-1:0] l0 [PIC_WIDTH];
  logic [WIDTH-1:0] l1 [PIC_WIDTH];
  logic [WIDTH-1:0] l2 [PIC_WIDTH];
  logic [WIDTH-1:0] l3 [PIC_WIDTH];

  logic [WIDTH-1:0] rd0;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] rd3;

  logic             col_last;
  logic             row_last;
  logic             primed;

  assign addr     = col_cnt[AW-1:0];
  assign col_last = (col_cnt == COL_LAST);
  assign row_last = (row_cnt == ROW_LAST);
  assign primed   = (row_cnt >= PRIME_ROWS);

  assign rd0 = l0[addr];
  assign rd1 = l1[addr];
  assign rd2 = l2[addr];
  assign rd3 = l3[addr];

  // Read-before-write cascade: each line shifts down one RAM.
  always_ff @(posedge clk) begin
    if (bus.valid_in) begin
      l0[addr] <= bus.din;
      l1[addr] <= rd0;
      l2[addr] <= rd1;
      l3[addr] <= rd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (bus.valid_in) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_last ? '0 : row_cnt + 9'd1;
      end else begin
        col_cnt <= col_cnt + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout1 <= '0;
      bus.dout2 <= '0;
      bus.dout3 <= '0;
      bus.dout4 <= '0;
      bus.dout5 <= '0;
    end else if (bus.valid_in) begin
      bus.dout1 <= rd3;
      bus.dout2 <= rd2;
      bus.dout3 <= rd1;
      bus.dout4 <= rd0;
      bus.dout5 <= bus.din;
    end
  end

  // Flags are one-cycle pulses; gaps force them low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_out <= 1'b0;
      bus.eol_out   <= 1'b0;
      bus.eof_out   <= 1'b0;
    end else begin
      bus.valid_out <= bus.valid_in && primed;
      bus.eol_out   <= bus.valid_in && primed && col_last;
      bus.eof_out   <= bus.valid_in && primed
                       && col_last && row_last;
    end
  end

endmodule
